// File: rtl/fifo_wordpack.sv
// fifo_wordpack: drains an asynchronous-read FIFO of BW-bit entries and packs
// NB of them little-endian (lane 0 = oldest) into one output word, presented on
// a valid/ready stream with a per-lane strobe. Partial words leave on an explicit
// flush (o_last=1) or after TIMEOUT idle cycles (o_last=0).
//
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_empty, i_data, o_rd   FIFO read port (o_rd is the combinational pop strobe)
//   i_flush                 single-cycle request to emit the pending partial word
//   o_valid, i_ready        output handshake
//   o_word, o_strb, o_last  packed word, contiguous lane mask, flush marker
//   o_busy                  assembly, output or flush activity outstanding
module fifo_wordpack #(
    parameter int unsigned BW      = 8,
    parameter int unsigned NB      = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned LGTO    = 5
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_empty,
    input  logic [BW-1:0]    i_data,
    output logic             o_rd,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [NB*BW-1:0] o_word,
    output logic [NB-1:0]    o_strb,
    output logic             o_last,
    output logic             o_busy
);

    localparam int unsigned WW = NB * BW;
    localparam int unsigned CW = $clog2(NB + 1);

    logic [WW-1:0]   asm_q, asm_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            flush_pend_q, flush_pend_d;
    logic [LGTO-1:0] idle_q, idle_d;
    logic            valid_q, valid_d;
    logic [WW-1:0]   word_q, word_d;
    logic [NB-1:0]   strb_q, strb_d;
    logic            last_q, last_d;
    logic            busy_q, busy_d;

    logic            out_free;
    logic            to_hit;
    logic            cnt_full;
    logic            xfer;
    logic [NB-1:0]   strb_c;
    logic [WW-1:0]   word_c;

    // Transfer decision and FIFO pop strobe.
    always_comb begin
        out_free = !valid_q || i_ready;
        to_hit   = (TIMEOUT != 0) && (idle_q == LGTO'(TIMEOUT));
        cnt_full = (cnt_q == CW'(NB));
        xfer     = out_free && (cnt_full || (flush_pend_q && (cnt_q != '0)) || to_hit);
        o_rd     = !i_empty && !i_flush && !flush_pend_q && (!cnt_full || xfer);
    end

    // Lane mask for the current fill level; unfilled lanes are forced to zero.
    always_comb begin
        strb_c = '0;
        word_c = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            strb_c[i] = (CW'(i) < cnt_q);
            if (strb_c[i]) begin
                word_c[i*BW +: BW] = asm_q[i*BW +: BW];
            end
        end
    end

    // Next-state for assembly buffer, counters and output register.
    always_comb begin
        asm_d        = asm_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        word_d       = word_q;
        strb_d       = strb_q;
        last_d       = last_q;
        idle_d       = idle_q;
        flush_pend_d = i_flush || (flush_pend_q && !xfer && (cnt_q != '0));

        if (xfer) begin
            word_d  = word_c;
            strb_d  = strb_c;
            last_d  = flush_pend_q;
            valid_d = 1'b1;
            asm_d   = '0;
            cnt_d   = '0;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        // A pop lands in the lane after whatever survives the transfer above.
        if (o_rd) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (cnt_d == CW'(i)) begin
                    asm_d[i*BW +: BW] = i_data;
                end
            end
            cnt_d = cnt_d + CW'(1);
        end

        if (o_rd || xfer || (cnt_q == '0)) begin
            idle_d = '0;
        end else if (!flush_pend_q && !cnt_full && (idle_q < LGTO'(TIMEOUT))) begin
            idle_d = idle_q + LGTO'(1);
        end

        busy_d = (cnt_d != '0) || valid_d || flush_pend_d;
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            asm_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            idle_q       <= '0;
            valid_q      <= 1'b0;
            word_q       <= '0;
            strb_q       <= '0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            idle_q       <= idle_d;
            valid_q      <= valid_d;
            word_q       <= word_d;
            strb_q       <= strb_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
        end
    end

    assign o_valid = valid_q;
    assign o_word  = word_q;
    assign o_strb  = strb_q;
    assign o_last  = last_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_fifo_wordpack.sv
// Testbench for fifo_wordpack: a queue stands in for the FIFO, popped whenever
// o_rd is high; expected words are built from the pushed bytes by little-endian
// packing and compared with what the output stream delivers.
module tb_fifo_wordpack;

    localparam int unsigned BW      = 8;
    localparam int unsigned NB      = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned LGTO    = 5;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_empty;
    logic [7:0]    i_data;
    logic          o_rd;
    logic          i_flush;
    logic          o_valid;
    logic          i_ready;
    logic [31:0]   o_word;
    logic [3:0]    o_strb;
    logic          o_last;
    logic          o_busy;

    fifo_wordpack #(.BW(BW), .NB(NB), .TIMEOUT(TIMEOUT), .LGTO(LGTO)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_empty   (i_empty),
        .i_data    (i_data),
        .o_rd      (o_rd),
        .i_flush   (i_flush),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_word    (o_word),
        .o_strb    (o_strb),
        .o_last    (o_last),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  fq[$];     // FIFO contents
    logic [7:0]  src[$];    // every byte pushed in the current test, in order
    logic [31:0] got_w[$];
    logic [3:0]  got_s[$];
    logic        got_l[$];
    int          got_t[$];
    int          tick_no = 0;
    logic        rdy  = 1'b1;
    logic        flsh = 1'b0;
    logic        popped;

    // One clock cycle, entered and left at a falling edge.
    task automatic tick();
        i_empty = (fq.size() == 0);
        i_data  = i_empty ? 8'h00 : fq[0];
        i_ready = rdy;
        i_flush = flsh;
        #1;
        popped = o_rd;
        if (o_rd && fq.size() != 0) void'(fq.pop_front());
        if (o_valid && i_ready) begin
            got_w.push_back(o_word);
            got_s.push_back(o_strb);
            got_l.push_back(o_last);
            got_t.push_back(tick_no);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        flsh = 1'b0;
        tick_no++;
    endtask

    task automatic push_byte(input logic [7:0] v);
        fq.push_back(v);
        src.push_back(v);
    endtask

    task automatic new_test();
        src.delete();
        got_w.delete();
        got_s.delete();
        got_l.delete();
        got_t.delete();
    endtask

    // Reference packing: n bytes of src starting at 'start', lane 0 = oldest.
    function automatic logic [31:0] pack(input int start, input int n);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < n; i++) w[i*8 +: 8] = src[start + i];
        return w;
    endfunction

    function automatic logic [3:0] strb_of(input int n);
        return 4'((1 << n) - 1);
    endfunction

    task automatic test_reset();
        i_reset_n = 1'b0;
        fq.delete();
        i_empty = 1'b1; i_data = 8'h00; i_flush = 1'b0; i_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if ({o_valid, o_last, o_busy, o_strb, o_word} !== 39'h0)
            begin errors++; $display("FAIL reset_outputs got=%h exp=0", {o_valid, o_last, o_busy, o_strb, o_word}); end
        checks++;
        if (o_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got=%b exp=0", o_rd); end
        i_reset_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_stream();
        int base, pc;
        for (int rep = 0; rep < 3; rep++) begin
            new_test();
            rdy = 1'b1;
            for (int i = 0; i < 8; i++)
                push_byte(rep == 0 ? 8'(8'h11 * (i + 1)) : 8'($urandom_range(0, 255)));
            base = tick_no;
            pc   = 0;
            for (int i = 0; i < 8; i++) begin tick(); if (popped) pc++; end
            for (int k = 0; k < 10 && got_w.size() < 2; k++) tick();
            checks++;
            if (pc != 8) begin errors++; $display("FAIL stream_pops got=%0d exp=8", pc); end
            checks++;
            if (got_w.size() != 2) begin errors++; $display("FAIL stream_count got=%0d exp=2", got_w.size()); end
            for (int i = 0; i < 2 && i < got_w.size(); i++) begin
                checks++;
                if ({got_l[i], got_s[i], got_w[i]} !== {1'b0, 4'hF, pack(4 * i, 4)})
                    begin errors++; $display("FAIL stream_word%0d got=%h/%h/%b exp=%h/F/0", i, got_w[i], got_s[i], got_l[i], pack(4 * i, 4)); end
                checks++;
                if (got_t[i] - base != 5 + 4 * i)
                    begin errors++; $display("FAIL stream_latency%0d got=%0d exp=%0d", i, got_t[i] - base, 5 + 4 * i); end
            end
            checks++;
            if (o_busy !== 1'b0) begin errors++; $display("FAIL stream_idle_busy got=%b exp=0", o_busy); end
        end
    endtask

    task automatic test_flush();
        int base;
        logic [5:0] pr;
        for (int rep = 0; rep < 2; rep++) begin
            new_test();
            rdy = 1'b1;
            for (int i = 0; i < 3; i++)
                push_byte(rep == 0 ? 8'(8'hAA + 8'h11 * i) : 8'($urandom_range(0, 255)));
            base = tick_no;
            pr   = '0;
            for (int i = 0; i < 6; i++) begin
                if (i == 2) flsh = 1'b1;
                tick();
                pr[i] = popped;
            end
            for (int i = 6; i < 10; i++) begin
                if (i == 6) flsh = 1'b1;
                tick();
            end
            checks++;
            if (pr !== 6'b010011) begin errors++; $display("FAIL flush_pops got=%b exp=010011", pr); end
            checks++;
            if (got_w.size() != 2) begin errors++; $display("FAIL flush_count got=%0d exp=2", got_w.size()); end
            if (got_w.size() >= 1) begin
                checks++;
                if ({got_l[0], got_s[0], got_w[0], 8'(got_t[0] - base)} !== {1'b1, 4'h3, pack(0, 2), 8'd4})
                    begin errors++; $display("FAIL flush_word0 got=%h/%h/%b@%0d exp=%h/3/1@4", got_w[0], got_s[0], got_l[0], got_t[0] - base, pack(0, 2)); end
            end
            if (got_w.size() >= 2) begin
                checks++;
                if ({got_l[1], got_s[1], got_w[1], 8'(got_t[1] - base)} !== {1'b1, 4'h1, pack(2, 1), 8'd8})
                    begin errors++; $display("FAIL flush_word1 got=%h/%h/%b@%0d exp=%h/1/1@8", got_w[1], got_s[1], got_l[1], got_t[1] - base, pack(2, 1)); end
            end
        end
    endtask

    task automatic test_timeout();
        int base, n;
        for (int rep = 0; rep < 3; rep++) begin
            new_test();
            rdy = 1'b1;
            n = (rep == 0) ? 1 : (rep == 1) ? 3 : int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++)
                push_byte((rep == 0) ? 8'h5A : 8'($urandom_range(0, 255)));
            base = tick_no;
            for (int k = 0; k < 40 && got_w.size() < 1; k++) tick();
            checks++;
            if (got_w.size() != 1) begin
                errors++; $display("FAIL timeout_count n=%0d got=%0d exp=1", n, got_w.size());
            end else begin
                checks++;
                if ({got_l[0], got_s[0], got_w[0]} !== {1'b0, strb_of(n), pack(0, n)})
                    begin errors++; $display("FAIL timeout_word got=%h/%h/%b exp=%h/%h/0", got_w[0], got_s[0], got_l[0], pack(0, n), strb_of(n)); end
                checks++;
                if (got_t[0] - base != n + 1 + int'(TIMEOUT))
                    begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", got_t[0] - base, n + 1 + int'(TIMEOUT)); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int pc;
        new_test();
        rdy = 1'b0;
        for (int i = 0; i < 12; i++) push_byte(8'($urandom_range(0, 255)));
        pc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (popped) pc++;
            if (i >= 4) begin
                checks++;
                if ({o_valid, o_strb, o_word} !== {1'b1, 4'hF, pack(0, 4)})
                    begin errors++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%h exp=1/F/%h", i, o_valid, o_strb, o_word, pack(0, 4)); end
            end
        end
        checks++;
        if (pc != 8 || fq.size() != 4)
            begin errors++; $display("FAIL bp_pops got=%0d left=%0d exp=8 left=4", pc, fq.size()); end
        checks++;
        if (o_rd !== 1'b0) begin errors++; $display("FAIL bp_rd_blocked got=%b exp=0", o_rd); end
        rdy = 1'b1;
        for (int k = 0; k < 20 && got_w.size() < 3; k++) tick();
        tick();
        checks++;
        if (got_w.size() != 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", got_w.size()); end
        for (int i = 0; i < 3 && i < got_w.size(); i++) begin
            checks++;
            if ({got_l[i], got_s[i], got_w[i]} !== {1'b0, 4'hF, pack(4 * i, 4)})
                begin errors++; $display("FAIL bp_word%0d got=%h/%h/%b exp=%h/F/0", i, got_w[i], got_s[i], got_l[i], pack(4 * i, 4)); end
        end
    endtask

    task automatic test_random_stream();
        int nw;
        new_test();
        nw = int'($urandom_range(3, 6));
        for (int i = 0; i < 4 * nw; i++) push_byte(8'($urandom_range(0, 255)));
        for (int k = 0; k < 400 && got_w.size() < nw; k++) begin
            rdy = 1'($urandom_range(0, 1));
            tick();
        end
        rdy = 1'b1;
        tick();
        checks++;
        if (got_w.size() != nw) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got_w.size(), nw); end
        for (int i = 0; i < nw && i < got_w.size(); i++) begin
            checks++;
            if ({got_l[i], got_s[i], got_w[i]} !== {1'b0, 4'hF, pack(4 * i, 4)})
                begin errors++; $display("FAIL rand_word%0d got=%h/%h/%b exp=%h/F/0", i, got_w[i], got_s[i], got_l[i], pack(4 * i, 4)); end
        end
    endtask

    task automatic test_flush_empty();
        new_test();
        rdy  = 1'b1;
        flsh = 1'b1;
        tick();
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL fe_pending_busy got=%b exp=1", o_busy); end
        tick();
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL fe_cleared_busy got=%b exp=0", o_busy); end
        repeat (3) tick();
        checks++;
        if (got_w.size() != 0) begin errors++; $display("FAIL fe_no_word got=%0d exp=0", got_w.size()); end

        new_test();
        push_byte(8'($urandom_range(0, 255)));
        push_byte(8'($urandom_range(0, 255)));
        for (int i = 0; i < 8; i++) begin
            flsh = (i == 2 || i == 3);
            tick();
        end
        checks++;
        if (got_w.size() != 1) begin errors++; $display("FAIL fe_double_count got=%0d exp=1", got_w.size()); end
        if (got_w.size() >= 1) begin
            checks++;
            if ({got_l[0], got_s[0], got_w[0]} !== {1'b1, 4'h3, pack(0, 2)})
                begin errors++; $display("FAIL fe_double_word got=%h/%h/%b exp=%h/3/1", got_w[0], got_s[0], got_l[0], pack(0, 2)); end
        end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL fe_end_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_reset_mid();
        new_test();
        rdy = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 255)));
        repeat (6) tick();
        checks++;
        if ({o_valid, o_busy} !== 2'b11) begin errors++; $display("FAIL rm_setup got=%b exp=11", {o_valid, o_busy}); end
        i_reset_n = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_busy, o_strb, o_word} !== 38'h0)
            begin errors++; $display("FAIL rm_async_clear got=%b/%b/%h/%h exp=0", o_valid, o_busy, o_strb, o_word); end
        fq.delete();
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        new_test();
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
        for (int k = 0; k < 12 && got_w.size() < 1; k++) tick();
        checks++;
        if (got_w.size() != 1) begin
            errors++; $display("FAIL rm_count got=%0d exp=1", got_w.size());
        end else begin
            checks++;
            if ({got_l[0], got_s[0], got_w[0]} !== {1'b0, 4'hF, pack(0, 4)})
                begin errors++; $display("FAIL rm_word got=%h/%h/%b exp=%h/F/0", got_w[0], got_s[0], got_l[0], pack(0, 4)); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_flush();
        test_timeout();
        test_backpressure();
        test_random_stream();
        test_flush_empty();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wordpack.md
Name: fifo_wordpack

Overview:
Downstream consumer of the synchronous data FIFO's read port. It pops BW-bit entries, packs NB of them little-endian into one output word, and presents each word on a valid/ready stream with a per-lane strobe. Partial words leave the block on an explicit flush or after a programmable idle timeout. Typical use: draining a byte FIFO (UART/SPI receive) onto a 32-bit bus-side stream.

Parameters:
BW, 8, width of each FIFO entry (lane width)
NB, 4, lanes per output word; NB >= 2
TIMEOUT, 16, idle cycles before a partial word is emitted; 0 disables the timeout
LGTO, 5, width of the idle counter; must satisfy 2**LGTO > TIMEOUT

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_reset_n  in  1  asynchronous, active-low reset
i_empty  in  1  FIFO empty flag (connects to the FIFO's o_empty)
i_data  in  BW  FIFO head data, valid in the same cycle (asynchronous-read FIFO)
o_rd  out  1  FIFO pop strobe, combinational
i_flush  in  1  single-cycle request to emit the pending partial word
o_valid  out  1  output word valid
i_ready  in  1  downstream accepts the word when o_valid && i_ready
o_word  out  NB*BW  packed word; lane 0 = bits BW-1:0 = oldest entry
o_strb  out  NB  per-lane valid mask, contiguous from lane 0
o_last  out  1  word was emitted because of i_flush
o_busy  out  1  cnt != 0 || o_valid || flush_pend

Behaviour:
- Reset (async assert, sync release): o_valid=0, o_word=0, o_strb=0, o_last=0; internal cnt=0, asm buffer=0, idle=0, flush_pend=0.
- State: asm[NB*BW], cnt in 0..NB, flush_pend, idle[LGTO], plus the output register.
- out_free = !o_valid || i_ready.
- xfer = out_free && (cnt==NB || (flush_pend && cnt!=0) || to_hit).
- to_hit = (TIMEOUT!=0) && (idle==TIMEOUT).
- o_rd = !i_empty && !i_flush && !flush_pend && (cnt<NB || xfer). A pop occurs exactly when o_rd=1.
- Pop without xfer: asm lane cnt <= i_data; cnt <= cnt+1.
- xfer: the output register loads o_word <= asm with unfilled lanes forced to 0, o_strb <= (1<<cnt)-1 (all ones when cnt==NB), o_last <= flush_pend, o_valid <= 1. asm is cleared and cnt <= 0. A pop in the same cycle writes lane 0 and sets cnt <= 1, which gives a sustained throughput of one entry per cycle.
- No xfer and o_valid && i_ready: o_valid <= 0.
- While o_valid && !i_ready: o_word, o_strb and o_last are held stable.
- Latency: the NB-th pop at cycle t gives cnt==NB at t+1, and o_valid=1 at t+2 when the output is free.
- cnt==NB with the output blocked: o_rd=0 (no pop) until xfer.
- Flush:
  - i_flush at t: o_rd=0 at t; flush_pend=1 from t+1.
  - While pending: no pops. xfer fires once out_free, with o_last=1; flush_pend clears on that xfer.
  - If cnt==0 when flush_pend is evaluated: flush_pend clears with no output word.
  - i_flush while already pending: merged, no second word.
  - Flush with cnt==NB: full word emitted with o_last=1.
- Timeout:
  - idle increments each cycle with 0<cnt<NB, !flush_pend, and no pop; it saturates at TIMEOUT.
  - idle resets to 0 on any pop, on xfer, or when cnt==0.
  - A timeout word has o_last=0.
  - If both flush_pend and to_hit hold, the word has o_last=1.
- Reset mid-operation clears everything immediately. Bytes already popped are lost; the FIFO is expected to be reset alongside.

Test Plan:
1. NB=4, FIFO holds 11 22 33 44 55 66 77 88, i_ready=1 -> o_rd high 8 consecutive cycles; words 0x44332211 then 0x88776655; o_strb=4'hF; o_last=0; one entry per cycle sustained.
2. Push AA BB, pulse i_flush after the second pop -> one word 0x0000BBAA, o_strb=4'h3, o_last=1; o_rd low while flush_pend; a later byte CC starts a new word at lane 0.
3. Push 5A only, TIMEOUT=16, no flush -> after exactly 16 idle cycles xfer fires: o_word=0x0000005A, o_strb=4'h1, o_last=0.
4. i_ready=0 with a word valid, FIFO holds 8 bytes -> o_word/o_strb stable; exactly 4 more pops, then o_rd=0 with cnt=4; raise i_ready -> both words delivered in order, no loss or duplication.
5. i_flush with cnt=0 and o_valid=0 -> no word emitted, flush_pend clears next cycle. i_flush twice within a pending flush -> single word.
6. Drop i_reset_n mid-word (cnt=2, o_valid=1) -> o_valid, o_strb, o_word, o_busy go 0 asynchronously; after release the next 4 bytes form a clean word at lanes 0..3.
